// File: rtl/asym_fifo_ctrl_pkg.sv
// Shared constants, helper functions and the parameter-consistency check
// for the asymmetric (narrow-write / wide-read) FIFO controller.
`define ASYM_FIFO_CTRL_CHECK_PARAMS(awa, dwa, awb, dwb) \
  if (((dwb) % (dwa)) != 0) begin : g_chk_ratio \
    $error("asym fifo ctrl: DWB must be a multiple of DWA"); \
  end \
  if ((awa) != ((awb) + asym_fifo_ctrl_pkg::log2_f((dwb) / (dwa)))) begin : g_chk_aw \
    $error("asym fifo ctrl: AWA must equal AWB + log2(DWB/DWA)"); \
  end

package asym_fifo_ctrl_pkg;

  localparam int OBUF_DEPTH = 4;
  localparam int OBUF_CW    = 3;

  function automatic int ratio_f(input int dwa, input int dwb);
    return dwb / dwa;
  endfunction

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/asym_wide_rd_fifo_ctrl_if.sv
// Stream interface of the FIFO controller: narrow beats in, wide words out.
// The slave modport is the controller's view, master is the environment's.
interface asym_wide_rd_fifo_ctrl_if #(
  parameter int DWA = 4,
  parameter int DWB = 16
);
  logic           s_valid;
  logic           s_ready;
  logic [DWA-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [DWB-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/asym_fifo_obuf.sv
// Small first-word-fall-through output buffer holding wide words returned
// by the RAM; the controller's read credit keeps it from overflowing.
module asym_fifo_obuf
  import asym_fifo_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [DW-1:0]      data,
  output logic [OBUF_CW-1:0] cnt
);
  localparam int PW = log2_f(OBUF_DEPTH);

  logic [DW-1:0]         mem_reg [OBUF_DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [OBUF_CW-1:0]    cnt_reg;
  logic [OBUF_DEPTH-1:0] wen;

  for (genvar gi = 0; gi < OBUF_DEPTH; gi++) begin : g_wen
    assign wen[gi] = push && (wr_ptr_reg == PW'(gi));
  end

  // Entries are cleared so m_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (wen[i]) mem_reg[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      cnt_reg <= cnt_reg + OBUF_CW'(push) - OBUF_CW'(pop);
    end
  end

  assign data = mem_reg[rd_ptr_reg];
  assign cnt  = cnt_reg;

endmodule

// File: rtl/asym_wide_rd_fifo_ctrl.sv
// Narrow-write / wide-read FIFO controller driving a simple-dual-port RAM
// with a 2-cycle read. Optional level/almost_full outputs: ASYM_FIFO_CTRL_LEVEL_EN.
module asym_wide_rd_fifo_ctrl
  import asym_fifo_ctrl_pkg::*;
#(
  parameter int AWA = 10,
  parameter int DWA = 4,
  parameter int AWB = 8,
  parameter int DWB = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  asym_wide_rd_fifo_ctrl_if.slave bus,
  output logic                    ram_wea,
  output logic [AWA-1:0]          ram_addra,
  output logic [DWA-1:0]          ram_dina,
  output logic                    ram_reb,
  output logic [AWB-1:0]          ram_addrb,
  input  logic [DWB-1:0]          ram_doutb
`ifdef ASYM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [AWA:0]            level,
  output logic                    almost_full
`endif
);
  localparam int RATIO  = ratio_f(DWA, DWB);
  localparam int LR     = log2_f(RATIO);
  localparam int DEPTHA = 1 << AWA;

  `ASYM_FIFO_CTRL_CHECK_PARAMS(AWA, DWA, AWB, DWB)

  logic [AWA:0]       wp_reg, wp_next, wc_reg;
  logic [AWB:0]       rp_reg, rp_next;
  logic [1:0]         inflight_reg;
  logic [AWA:0]       rps, fill;
  logic [AWB:0]       avail;
  logic [OBUF_CW:0]   credit_used;
  logic [OBUF_CW-1:0] obuf_cnt;
  logic               full, accept, issue, pop;

  assign rps    = {rp_reg, {LR{1'b0}}};
  assign fill   = wp_reg - rps;
  assign full   = (fill == (AWA+1)'(DEPTHA));
  assign accept = bus.s_valid && !full;

  assign bus.s_ready = !full;
  assign ram_wea     = accept;
  assign ram_addra   = wp_reg[AWA-1:0];
  assign ram_dina    = bus.s_data;

  // Only whole wide words that the RAM has already committed are readable.
  assign avail       = wc_reg[AWA:LR] - rp_reg;
  assign credit_used = (OBUF_CW+1)'(inflight_reg[0]) + (OBUF_CW+1)'(inflight_reg[1])
                     + (OBUF_CW+1)'(obuf_cnt);
  assign issue       = (avail != '0) && (credit_used < (OBUF_CW+1)'(OBUF_DEPTH));
  assign ram_reb     = issue;
  assign ram_addrb   = rp_reg[AWB-1:0];

  assign wp_next = wp_reg + (AWA+1)'(accept);
  assign rp_next = rp_reg + (AWB+1)'(issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg       <= '0;
      wc_reg       <= '0;
      rp_reg       <= '0;
      inflight_reg <= '0;
    end else begin
      wp_reg       <= wp_next;
      wc_reg       <= wp_reg;
      rp_reg       <= rp_next;
      inflight_reg <= {inflight_reg[0], issue};
    end
  end

  assign bus.m_valid = (obuf_cnt != '0);
  assign pop         = bus.m_valid && bus.m_ready;

  // Read data arrives two cycles after issue, tracked by inflight_reg[1].
  asym_fifo_obuf #(.DW(DWB)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg[1]),
    .push_data (ram_doutb),
    .pop       (pop),
    .data      (bus.m_data),
    .cnt       (obuf_cnt)
  );

`ifdef ASYM_FIFO_CTRL_LEVEL_EN
  logic [AWA:0] level_reg, level_next;
  logic         almost_full_reg;

  assign level_next = wp_next - {rp_next, {LR{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg       <= '0;
      almost_full_reg <= 1'b0;
    end else begin
      level_reg       <= level_next;
      almost_full_reg <= (level_next >= (AWA+1)'(DEPTHA - 2*RATIO));
    end
  end

  assign level       = level_reg;
  assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_asym_wide_rd_fifo_ctrl.sv
// Self-checking bench for asym_wide_rd_fifo_ctrl: behavioural RAM, word-level
// reference queue, directed and randomized phases.
module tb_asym_wide_rd_fifo_ctrl;
  localparam int AWA = 10, DWA = 4, AWB = 8, DWB = 16;
  localparam int RATIO = DWB / DWA;
  localparam int DEPTHA = 1 << AWA;
  localparam int OBUF_WORDS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  asym_wide_rd_fifo_ctrl_if #(.DWA(DWA), .DWB(DWB)) bus ();

  logic           ram_wea, ram_reb;
  logic [AWA-1:0] ram_addra;
  logic [DWA-1:0] ram_dina;
  logic [AWB-1:0] ram_addrb;
  logic [DWB-1:0] ram_doutb;
`ifdef ASYM_FIFO_CTRL_LEVEL_EN
  logic [AWA:0]   level;
  logic           almost_full;
`endif

  asym_wide_rd_fifo_ctrl #(.AWA(AWA), .DWA(DWA), .AWB(AWB), .DWB(DWB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_reb   (ram_reb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
`ifdef ASYM_FIFO_CTRL_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  // Behavioural RAM: inputs registered, write lands one edge later, read data two edges after reb.
  logic [DWA-1:0] ram_mem [DEPTHA];
  logic           wea_q, reb_q;
  logic [AWA-1:0] addra_q;
  logic [DWA-1:0] dina_q;
  logic [AWB-1:0] addrb_q;
  always @(posedge clk) begin
    wea_q   <= ram_wea;
    addra_q <= ram_addra;
    dina_q  <= ram_dina;
    reb_q   <= ram_reb;
    addrb_q <= ram_addrb;
    if (wea_q) ram_mem[addra_q] <= dina_q;
    if (reb_q)
      for (int k = 0; k < RATIO; k++) ram_doutb[k*DWA +: DWA] <= ram_mem[{addrb_q, 2'(k)}];
  end

  // Reference: narrow beats pack little-endian into wide words, delivered in order.
  logic [DWB-1:0] exp_q[$];
  int unsigned    part_val;
  int             part_n;
  int             tests = 0;
  int             failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_val = 0;
    part_n   = 0;
  endtask

  task automatic model_beat(input logic [DWA-1:0] b);
    part_val = part_val + (int'(b) << (DWA * part_n));
    part_n++;
    if (part_n == RATIO) begin
      exp_q.push_back(DWB'(part_val));
      part_val = 0;
      part_n   = 0;
    end
  endtask

  // One clock: sample handshakes mid-cycle, score them, return just after the edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = bus.s_valid && bus.s_ready;
    if (bus.m_valid && bus.m_ready) begin
      check("ref_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
    if (acc) model_beat(bus.s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit a;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (exp_q.size() == 0 && !bus.m_valid) break;
      tick(a);
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_m_valid_idle"}, 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit a;
    for (int n = 0; n < 50 && !bus.m_valid; n++) tick(a);
    check(tag, 32'(bus.m_valid), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cnt, sent;
    logic [15:0] seq;
    model_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_ram_wea", 32'(ram_wea), 32'd0);
    check("rst_ram_reb", 32'(ram_reb), 32'd0);
`ifdef ASYM_FIFO_CTRL_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word: m_valid appears on the 4th edge after the completing beat
    for (int i = 1; i <= 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DWA'(i);
      tick(acc);
      check("single_accept", 32'(acc), 32'd1);
    end
    bus.s_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("single_m_valid_edge%0d", k), 32'(bus.m_valid), 32'(k == 4));
    end
    check("single_m_data", 32'(bus.m_data), 32'h4321);
    bus.m_ready = 1'b1;
    tick(acc);
    bus.m_ready = 1'b0;
    check("single_after_pop", 32'(bus.m_valid), 32'd0);

    // Partial word is never read until completed
    for (int i = 1; i <= 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DWA'(i);
      tick(acc);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      tick(acc);
      if (bus.m_valid) cnt++;
    end
    check("partial_no_output", 32'(cnt), 32'd0);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'hA;
    tick(acc);
    bus.s_valid = 1'b0;
    wait_valid("partial_timeout");
    check("partial_m_data", 32'(bus.m_data), 32'hA321);
    drain("partial");

    // Full: RAM holds DEPTHA beats beyond rp, plus the words already moved to the output buffer
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.s_data = DWA'($urandom);
      tick(acc);
      if (acc) cnt++;
      if (!bus.s_ready) break;
    end
    check("full_beats_accepted", 32'(cnt), 32'(DEPTHA + RATIO * OBUF_WORDS));
    check("full_s_ready", 32'(bus.s_ready), 32'd0);
`ifdef ASYM_FIFO_CTRL_LEVEL_EN
    check("full_level", 32'(level), 32'(DEPTHA));
    check("full_almost_full", 32'(almost_full), 32'd1);
`endif
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      tick(acc);
      if (acc) cnt++;
    end
    check("full_holds", 32'(cnt), 32'd0);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick(acc);
    bus.m_ready = 1'b0;
    check("full_s_ready_after_pop", 32'(bus.s_ready), 32'd0);
    tick(acc);
    check("full_s_ready_after_issue", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      bus.s_data = DWA'($urandom);
      tick(acc);
      if (acc) cnt++;
    end
    check("full_refill_beats", 32'(cnt), 32'(RATIO));
    drain("full");

    // Wrap: 3000 incrementing beats with random valid/ready
    seq  = '0;
    sent = 0;
    for (int n = 0; n < 20000 && sent < 3000; n++) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = seq[3:0];
      bus.m_ready = $urandom_range(0, 1);
      tick(acc);
      if (acc) begin
        seq++;
        sent++;
      end
    end
    check("wrap_sent", 32'(sent), 32'd3000);
    drain("wrap");

    // Back-to-back: one beat per cycle gives one word every RATIO cycles
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      bus.s_data = DWA'($urandom);
      tick(acc);
    end
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      bus.s_data = DWA'($urandom);
      tick(acc);
      if (bus.m_valid) cnt++;
    end
    check("b2b_words", 32'(cnt), 32'(200 / RATIO));
    drain("b2b");

    // Async reset with data buffered and reads in flight
    bus.s_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bus.s_data = DWA'($urandom);
      tick(acc);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick(acc);
    tick(acc);
    bus.m_ready = 1'b0;
    tick(acc);
    check("pre_reset_m_valid", 32'(bus.m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(bus.m_valid), 32'd0);
    check("arst_s_ready", 32'(bus.s_ready), 32'd1);
    check("arst_ram_reb", 32'(ram_reb), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < RATIO; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DWA'($urandom);
      tick(acc);
    end
    bus.s_valid = 1'b0;
    wait_valid("post_reset_timeout");
    check("post_reset_m_data", 32'(bus.m_data), 32'(exp_q.size() != 0 ? exp_q[0] : 16'h0));
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
